// File: rtl/wb_gain_apply.sv
// White-balance gain stage: per-channel gain, round-half-up, saturate, 2-stage valid/ready pipe.
// Optional frame clip counter (clip_cnt_o) is built when WB_CLIP_CNT_EN is defined.
module wb_gain_apply #(
    parameter int GAIN_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gain_valid_i,
    input  logic [GAIN_W-1:0] K_R_i,
    input  logic [GAIN_W-1:0] K_G_i,
    input  logic [GAIN_W-1:0] K_B_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              sof_i,
    input  logic [7:0]        r_i,
    input  logic [7:0]        g_i,
    input  logic [7:0]        b_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sof_o,
    output logic [7:0]        r_o,
    output logic [7:0]        g_o,
    output logic [7:0]        b_o
`ifdef WB_CLIP_CNT_EN
    ,
    output logic [15:0]       clip_cnt_o
`endif
);

    localparam int                P_W   = 8 + GAIN_W;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << FRAC_W);
    localparam logic [P_W:0]      ROUND = (P_W+1)'(1 << (FRAC_W - 1));

    logic                   en, accept, sof_accept;
    logic [2:0][7:0]        pix_in;
    logic [2:0][GAIN_W-1:0] gain_in, sel_gain;
    logic [2:0][GAIN_W-1:0] act_gain_d, act_gain_q, pend_gain_d, pend_gain_q;
    logic                   pend_d, pend_q;
    logic                   valid1_d, valid1_q, sof1_d, sof1_q;
    logic [2:0][P_W-1:0]    prod_d, prod_q;
    logic [2:0][P_W:0]      rnd, quo;
    logic [2:0]             sat;
    logic [2:0][7:0]        res;
    logic                   valid2_d, valid2_q, sof2_d, sof2_q;
    logic [2:0][7:0]        pix2_d, pix2_q;

    // One enable for both stages: the pipe moves only when the output slot is free or draining.
    assign en         = ~valid2_q | ready_i;
    assign ready_o    = en;
    assign accept     = valid_i & en;
    assign sof_accept = accept & sof_i;
    assign pix_in     = {r_i, g_i, b_i};
    assign gain_in    = {K_R_i, K_G_i, K_B_i};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sel_gain    = act_gain_q;
        act_gain_d  = act_gain_q;
        pend_gain_d = pend_gain_q;
        pend_d      = pend_q;
        if (sof_accept && gain_valid_i) begin
            sel_gain = gain_in;
        end else if (sof_accept && pend_q) begin
            sel_gain = pend_gain_q;
        end
        if (sof_accept) begin
            act_gain_d = sel_gain;
            pend_d     = 1'b0;
        end else if (gain_valid_i) begin
            pend_gain_d = gain_in;
            pend_d      = 1'b1;
        end

        valid1_d = valid1_q;
        sof1_d   = sof1_q;
        prod_d   = prod_q;
        if (en) begin
            valid1_d = valid_i;
            sof1_d   = valid_i & sof_i;
            for (int c = 0; c < 3; c++) begin
                prod_d[c] = P_W'(pix_in[c]) * P_W'(sel_gain[c]);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            rnd[c] = {1'b0, prod_q[c]} + ROUND;
            quo[c] = rnd[c] >> FRAC_W;
            sat[c] = quo[c] > (P_W+1)'(255);
            res[c] = sat[c] ? 8'hFF : quo[c][7:0];
        end

        valid2_d = valid2_q;
        sof2_d   = sof2_q;
        pix2_d   = pix2_q;
        if (en) begin
            valid2_d = valid1_q;
            sof2_d   = sof1_q;
            pix2_d   = res;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_gain_q  <= {3{UNITY}};
            pend_gain_q <= '0;
            pend_q      <= 1'b0;
            valid1_q    <= 1'b0;
            sof1_q      <= 1'b0;
            prod_q      <= '0;
            valid2_q    <= 1'b0;
            sof2_q      <= 1'b0;
            pix2_q      <= '0;
        end else begin
            act_gain_q  <= act_gain_d;
            pend_gain_q <= pend_gain_d;
            pend_q      <= pend_d;
            valid1_q    <= valid1_d;
            sof1_q      <= sof1_d;
            prod_q      <= prod_d;
            valid2_q    <= valid2_d;
            sof2_q      <= sof2_d;
            pix2_q      <= pix2_d;
        end
    end

    assign valid_o = valid2_q;
    assign sof_o   = sof2_q;
    assign r_o     = pix2_q[2];
    assign g_o     = pix2_q[1];
    assign b_o     = pix2_q[0];

`ifdef WB_CLIP_CNT_EN
    logic [2:0]  sat2_d, sat2_q;
    logic [15:0] cnt_d, cnt_q, clip_d, clip_q;
    logic [1:0]  nsat;
    logic [16:0] cnt_sum;

    always_comb begin
        sat2_d  = en ? sat : sat2_q;
        nsat    = 2'(sat2_q[0]) + 2'(sat2_q[1]) + 2'(sat2_q[2]);
        cnt_sum = {1'b0, cnt_q} + 17'(nsat);
        cnt_d   = cnt_q;
        clip_d  = clip_q;
        if (valid2_q && ready_i) begin
            // A frame-start beat publishes the finished frame's total and seeds the new one.
            if (sof2_q) begin
                clip_d = cnt_q;
                cnt_d  = 16'(nsat);
            end else begin
                cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat2_q <= '0;
            cnt_q  <= '0;
            clip_q <= '0;
        end else begin
            sat2_q <= sat2_d;
            cnt_q  <= cnt_d;
            clip_q <= clip_d;
        end
    end

    assign clip_cnt_o = clip_q;
`endif

endmodule

// File: tb/tb_wb_gain_apply.sv
// Self-checking bench for wb_gain_apply: directed scenarios plus randomized traffic
// checked against a frame-level gain model and an in-order scoreboard.
module tb_wb_gain_apply;

    localparam int FRAC_W = 8;
    localparam int GAIN_W = 16;
    localparam int UNITY  = 1 << FRAC_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              gain_valid_i;
    logic [GAIN_W-1:0] K_R_i, K_G_i, K_B_i;
    logic              valid_i, ready_o, sof_i;
    logic [7:0]        r_i, g_i, b_i;
    logic              valid_o, ready_i, sof_o;
    logic [7:0]        r_o, g_o, b_o;
`ifdef WB_CLIP_CNT_EN
    logic [15:0]       clip_cnt_o;
`endif

    wb_gain_apply #(.GAIN_W(GAIN_W), .FRAC_W(FRAC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gain_valid_i (gain_valid_i),
        .K_R_i        (K_R_i),
        .K_G_i        (K_G_i),
        .K_B_i        (K_B_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .sof_i        (sof_i),
        .r_i          (r_i),
        .g_i          (g_i),
        .b_i          (b_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .sof_o        (sof_o),
        .r_o          (r_o),
        .g_o          (g_o),
        .b_o          (b_o)
`ifdef WB_CLIP_CNT_EN
        ,
        .clip_cnt_o   (clip_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic sof;
        int   r, g, b;
        int   nsat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   act_g[3];
    int   pend_g[3];
    bit   m_pend;
    int   m_cnt, exp_clip;
    bit   stall_prev;
    logic [24:0] held;

    // Unclamped rounded product: (pix*gain + half) / 2^FRAC_W.
    function automatic longint raw_q(int pix, int gain);
        return (longint'(pix) * longint'(gain) + longint'(1 << (FRAC_W - 1))) >>> FRAC_W;
    endfunction

    function automatic int apply_gain(int pix, int gain);
        longint q = raw_q(pix, gain);
        return (q > 255) ? 255 : int'(q);
    endfunction

    task automatic model_reset();
        sb.delete();
        act_g      = '{UNITY, UNITY, UNITY};
        pend_g     = '{0, 0, 0};
        m_pend     = 1'b0;
        m_cnt      = 0;
        exp_clip   = 0;
        stall_prev = 1'b0;
    endtask

    // One clock cycle: check outputs, update model from this cycle's handshakes, advance to next negedge.
    task automatic step();
        exp_t e;
        int   kin[3];
        int   pin[3];
        #1;
`ifdef WB_CLIP_CNT_EN
        vectors++;
        if (clip_cnt_o !== 16'(exp_clip)) begin
            miscompares++;
            $display("FAIL clip_cnt: got %0d want %0d", clip_cnt_o, exp_clip);
        end
`endif
        vectors++;
        if (ready_o !== (!valid_o || ready_i)) begin
            miscompares++;
            $display("FAIL ready_o: got %b want %b", ready_o, (!valid_o || ready_i));
        end
        if (stall_prev) begin
            vectors++;
            if ({valid_o, sof_o, r_o, g_o, b_o} !== {1'b1, held}) begin
                miscompares++;
                $display("FAIL stall_hold: got %h want %h", {valid_o, sof_o, r_o, g_o, b_o}, {1'b1, held});
            end
        end
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL extra_beat: got r=%0d g=%0d b=%0d want none", r_o, g_o, b_o);
            end else begin
                e = sb.pop_front();
                if ({sof_o, r_o, g_o, b_o} !== {e.sof, 8'(e.r), 8'(e.g), 8'(e.b)}) begin
                    miscompares++;
                    $display("FAIL pixel: got sof=%b %0d,%0d,%0d want sof=%b %0d,%0d,%0d",
                             sof_o, r_o, g_o, b_o, e.sof, e.r, e.g, e.b);
                end
                if (e.sof) begin
                    exp_clip = m_cnt;
                    m_cnt    = e.nsat;
                end else begin
                    m_cnt = (m_cnt + e.nsat > 65535) ? 65535 : m_cnt + e.nsat;
                end
            end
        end
        kin = '{int'(K_R_i), int'(K_G_i), int'(K_B_i)};
        pin = '{int'(r_i), int'(g_i), int'(b_i)};
        if (valid_i && ready_o && sof_i) begin
            if (gain_valid_i)  act_g = kin;
            else if (m_pend)   act_g = pend_g;
            m_pend = 1'b0;
        end else if (gain_valid_i) begin
            pend_g = kin;
            m_pend = 1'b1;
        end
        if (valid_i && ready_o) begin
            e.sof  = sof_i;
            e.r    = apply_gain(pin[0], act_g[0]);
            e.g    = apply_gain(pin[1], act_g[1]);
            e.b    = apply_gain(pin[2], act_g[2]);
            e.nsat = 0;
            for (int c = 0; c < 3; c++) if (raw_q(pin[c], act_g[c]) > 255) e.nsat++;
            sb.push_back(e);
        end
        stall_prev = valid_o && !ready_i;
        held       = {sof_o, r_o, g_o, b_o};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_gains(int kr, int kg, int kb);
        gain_valid_i = 1'b1;
        K_R_i = GAIN_W'(kr); K_G_i = GAIN_W'(kg); K_B_i = GAIN_W'(kb);
        valid_i = 1'b0;
        step();
        gain_valid_i = 1'b0;
    endtask

    // Drive one beat then a bubble; afterwards that beat sits on the outputs.
    task automatic send1(logic sof, int r, int g, int b);
        ready_i = 1'b1; valid_i = 1'b1; sof_i = sof;
        r_i = 8'(r); g_i = 8'(g); b_i = 8'(b);
        step();
        valid_i = 1'b0; sof_i = 1'b0; gain_valid_i = 1'b0;
        step();
    endtask

    task automatic drain();
        valid_i = 1'b0; gain_valid_i = 1'b0; ready_i = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        step();
        vectors++;
        if (sb.size() != 0 || valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending beats want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({valid_o, sof_o, r_o, g_o, b_o, ready_o} !== {2'b00, 24'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_values: got v=%b s=%b %0d,%0d,%0d rdy=%b want 0 0 0,0,0 1",
                     valid_o, sof_o, r_o, g_o, b_o, ready_o);
        end
    endtask

    task automatic test_default_gain();
        ready_i = 1'b1; valid_i = 1'b1; sof_i = 1'b1;
        r_i = 8'd100; g_i = 8'd50; b_i = 8'd200;
        step();
        valid_i = 1'b0; sof_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got valid_o=%b want 0", valid_o);
        end
        step();
        vectors++;
        if ({valid_o, sof_o, r_o, g_o, b_o} !== {1'b1, 1'b1, 8'd100, 8'd50, 8'd200}) begin
            miscompares++;
            $display("FAIL default_gain: got v=%b s=%b %0d,%0d,%0d want 1 1 100,50,200",
                     valid_o, sof_o, r_o, g_o, b_o);
        end
    endtask

    task automatic test_gain_load();
        pulse_gains('h180, 'h100, 'h080);
        send1(1'b1, 100, 50, 201);
        vectors++;
        if ({sof_o, r_o, g_o, b_o} !== {1'b1, 8'd150, 8'd50, 8'd101}) begin
            miscompares++;
            $display("FAIL gain_load: got %0d,%0d,%0d want 150,50,101", r_o, g_o, b_o);
        end
    endtask

    task automatic test_round_sat();
        pulse_gains('h200, 'h100, 'h100);
        send1(1'b1, 200, 0, 0);
        vectors++;
        if (r_o !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate: got %0d want 255", r_o);
        end
        send1(1'b0, 127, 0, 0);
        vectors++;
        if (r_o !== 8'd254) begin
            miscompares++;
            $display("FAIL near_sat: got %0d want 254", r_o);
        end
        pulse_gains('h101, 'h100, 'h100);
        send1(1'b1, 128, 0, 0);
        vectors++;
        if (r_o !== 8'd129) begin
            miscompares++;
            $display("FAIL round_half_up: got %0d want 129", r_o);
        end
        pulse_gains(0, 'h100, 'h100);
        send1(1'b1, 255, 7, 9);
        vectors++;
        if ({r_o, g_o, b_o} !== {8'd0, 8'd7, 8'd9}) begin
            miscompares++;
            $display("FAIL zero_gain: got %0d,%0d,%0d want 0,7,9", r_o, g_o, b_o);
        end
    endtask

    task automatic test_mid_frame();
        pulse_gains('h100, 'h100, 'h100);
        send1(1'b1, 10, 60, 10);
        gain_valid_i = 1'b1;
        K_R_i = 16'h0100; K_G_i = 16'h0200; K_B_i = 16'h0100;
        send1(1'b0, 10, 60, 10);
        vectors++;
        if (g_o !== 8'd60) begin
            miscompares++;
            $display("FAIL mid_frame_hold: got %0d want 60", g_o);
        end
        send1(1'b0, 10, 60, 10);
        vectors++;
        if (g_o !== 8'd60) begin
            miscompares++;
            $display("FAIL mid_frame_hold2: got %0d want 60", g_o);
        end
        send1(1'b1, 10, 60, 10);
        vectors++;
        if (g_o !== 8'd120) begin
            miscompares++;
            $display("FAIL next_frame_gain: got %0d want 120", g_o);
        end
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; sof_i = (i == 0);
            r_i = 8'(20 + i); g_i = 8'(40 + i); b_i = 8'(60 + i);
            step();
        end
        ready_i = 1'b0;
        r_i = 8'd99; g_i = 8'd98; b_i = 8'd97; sof_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({valid_o, ready_o} !== 2'b10) begin
                miscompares++;
                $display("FAIL stall_ready: got valid_o=%b ready_o=%b want 1 0", valid_o, ready_o);
            end
        end
        ready_i = 1'b1;
        step();
        drain();
    endtask

    task automatic test_reset_mid();
        pulse_gains('h200, 'h200, 'h200);
        ready_i = 1'b1; valid_i = 1'b1; sof_i = 1'b0;
        r_i = 8'd1; g_i = 8'd2; b_i = 8'd3;
        step();
        step();
        ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({valid_o, sof_o, r_o, g_o, b_o, ready_o} !== {2'b00, 24'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b s=%b %0d,%0d,%0d rdy=%b want 0 0 0,0,0 1",
                     valid_o, sof_o, r_o, g_o, b_o, ready_o);
        end
        model_reset();
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send1(1'b1, 50, 50, 50);
        vectors++;
        if ({r_o, g_o, b_o} !== {8'd50, 8'd50, 8'd50}) begin
            miscompares++;
            $display("FAIL pending_lost: got %0d,%0d,%0d want 50,50,50", r_o, g_o, b_o);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            valid_i      = ($urandom_range(0, 3) != 0);
            sof_i        = ($urandom_range(0, 9) == 0);
            r_i          = 8'($urandom_range(0, 255));
            g_i          = 8'($urandom_range(0, 255));
            b_i          = 8'($urandom_range(0, 255));
            ready_i      = ($urandom_range(0, 3) != 0);
            gain_valid_i = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                K_R_i = 16'($urandom_range(0, 65535));
                K_G_i = 16'($urandom_range(0, 65535));
                K_B_i = 16'($urandom_range(0, 65535));
            end else begin
                K_R_i = 16'($urandom_range(0, 'h300));
                K_G_i = 16'($urandom_range(0, 'h300));
                K_B_i = 16'($urandom_range(0, 'h300));
            end
            step();
        end
        drain();
    endtask

`ifdef WB_CLIP_CNT_EN
    task automatic test_clip_cnt();
        pulse_gains('h200, 'h100, 'h200);
        send1(1'b1, 10, 10, 10);
        send1(1'b0, 200, 10, 200);
        send1(1'b0, 150, 10, 130);
        send1(1'b0, 20, 20, 20);
        send1(1'b0, 255, 10, 255);
        send1(1'b1, 1, 1, 1);
        step();
        vectors++;
        if (clip_cnt_o !== 16'd6) begin
            miscompares++;
            $display("FAIL clip_frame_total: got %0d want 6", clip_cnt_o);
        end
        drain();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        gain_valid_i = 1'b0; K_R_i = '0; K_G_i = '0; K_B_i = '0;
        valid_i = 1'b0; sof_i = 1'b0; r_i = '0; g_i = '0; b_i = '0;
        ready_i = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_default_gain();
        test_gain_load();
        test_round_sat();
        test_mid_frame();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef WB_CLIP_CNT_EN
        test_clip_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
